// File: rtl/icache_direct_mapped_if.sv
// Bus bundle for the icache: the fetch-side wishbone slave link and the refill-side wishbone master link.
interface icache_direct_mapped_if;
    logic [11:0]  cpu_adr;
    logic         cpu_stb;
    logic         cpu_cyc;
    logic         cpu_we;
    logic [127:0] cpu_dat_s;
    logic         cpu_ack;

    logic [11:0]  l2_adr;
    logic         l2_stb;
    logic         l2_cyc;
    logic         l2_we;
    logic [15:0]  l2_sel;
    logic [127:0] l2_dat_s;
    logic         l2_ack;

    // Cache-side view
    modport slave (
        input  cpu_adr, cpu_stb, cpu_cyc, cpu_we,
        output cpu_dat_s, cpu_ack,
        output l2_adr, l2_stb, l2_cyc, l2_we, l2_sel,
        input  l2_dat_s, l2_ack
    );

    // Environment view: the fetch master plus the L2/arbiter responder
    modport master (
        output cpu_adr, cpu_stb, cpu_cyc, cpu_we,
        input  cpu_dat_s, cpu_ack,
        input  l2_adr, l2_stb, l2_cyc, l2_we, l2_sel,
        output l2_dat_s, l2_ack
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with 128-bit lines, combinational hit ACK and wishbone refill.
// Optional next-line prefetch is enabled by defining ICACHE_NEXT_LINE_PREFETCH_EN.
module icache_direct_mapped #(
    parameter int SETS  = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    icache_direct_mapped_if.slave bus,
    input  logic                 inv,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    ,
    output logic [CNT_W-1:0]     pf_count
`endif
);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 12 - IDX;

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, PREFETCH = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1} state_t;
`endif

    state_t          state;
    logic [SETS-1:0] valid;
    logic [TAG-1:0]  tag_mem  [SETS];
    logic [127:0]    data_mem [SETS];
    logic            inv_seen;

    logic [IDX-1:0]  req_idx;
    logic [TAG-1:0]  req_tag;
    logic [IDX-1:0]  fill_idx;
    logic [TAG-1:0]  fill_tag;
    logic            req;
    logic            hit;
    logic            miss;
    logic            fill_done;

    assign req_idx   = bus.cpu_adr[IDX-1:0];
    assign req_tag   = bus.cpu_adr[11:IDX];
    assign fill_idx  = bus.l2_adr[IDX-1:0];
    assign fill_tag  = bus.l2_adr[11:IDX];
    assign req       = (state == IDLE) && bus.cpu_stb && bus.cpu_cyc && !bus.cpu_we;
    assign hit       = req && valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign miss      = req && !hit;
    // Any non-IDLE state is a refill in flight, so l2_ack is only honoured there
    assign fill_done = (state != IDLE) && bus.l2_ack;

    assign bus.cpu_ack   = hit;
    assign bus.cpu_dat_s = data_mem[req_idx];
    assign bus.l2_we     = 1'b0;
    assign bus.l2_sel    = 16'hFFFF;

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    logic [11:0]    nxt_adr;
    logic [IDX-1:0] nxt_idx;
    logic           nxt_present;
    logic           pf_pending;

    assign nxt_adr     = bus.l2_adr + 12'd1;
    assign nxt_idx     = nxt_adr[IDX-1:0];
    assign nxt_present = valid[nxt_idx] && (tag_mem[nxt_idx] == nxt_adr[11:IDX]);
`endif

    // Control FSM: refill sequencing, valid bits and hit/miss statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            bus.l2_adr <= 12'd0;
            bus.l2_stb <= 1'b0;
            bus.l2_cyc <= 1'b0;
            inv_seen   <= 1'b0;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
            pf_pending <= 1'b0;
            pf_count   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        hit_count <= hit_count + CNT_W'(1);
                    end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
                    if (pf_pending) begin
                        pf_pending <= 1'b0;
                        bus.l2_adr <= nxt_adr;
                        bus.l2_stb <= 1'b1;
                        bus.l2_cyc <= 1'b1;
                        inv_seen   <= 1'b0;
                        pf_count   <= pf_count + CNT_W'(1);
                        state      <= PREFETCH;
                    end else
`endif
                    if (miss) begin
                        bus.l2_adr <= bus.cpu_adr;
                        bus.l2_stb <= 1'b1;
                        bus.l2_cyc <= 1'b1;
                        inv_seen   <= 1'b0;
                        miss_count <= miss_count + CNT_W'(1);
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (bus.l2_ack) begin
                        valid[fill_idx] <= ~inv_seen;
                        bus.l2_stb      <= 1'b0;
                        bus.l2_cyc      <= 1'b0;
                        state           <= IDLE;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
                        pf_pending      <= ~nxt_present;
`endif
                    end else if (inv) begin
                        inv_seen <= 1'b1;
                    end
                end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
                PREFETCH: begin
                    if (bus.l2_ack) begin
                        valid[fill_idx] <= ~inv_seen;
                        bus.l2_stb      <= 1'b0;
                        bus.l2_cyc      <= 1'b0;
                        state           <= IDLE;
                    end else if (inv) begin
                        inv_seen <= 1'b1;
                    end
                end
`endif
                default: begin
                    bus.l2_stb <= 1'b0;
                    bus.l2_cyc <= 1'b0;
                    state      <= IDLE;
                end
            endcase
            // Invalidate overrides any valid bit set by a fill completing in the same cycle
            if (inv) begin
                valid <= '0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify their contents
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= bus.l2_dat_s;
        end
    end
endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, read-only L1 instruction cache sitting directly downstream of the pipeline's ifetch wishbone master.
- Serves 128-bit lines to the fetch stage; on a miss, refills through a wishbone master port toward the L2 or arbiter.
- Exports hit and miss counters, which feed the datapath's icache_hit_counter and icache_miss_counter inputs.

Parameters:
- SETS, 16, number of lines; power of two, 2..256. IDX = log2(SETS); TAG = 12 - IDX.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  system clock, the single clock domain.
- rst  in  1  asynchronous, active-high reset.
- cpu_adr  in  12  line address, bits [15:4] of the PC.
- cpu_stb  in  1  wishbone STB from ifetch.
- cpu_cyc  in  1  wishbone CYC from ifetch.
- cpu_we  in  1  wishbone WE; must be 0; writes are never acknowledged.
- cpu_dat_s  out  128  line data returned to fetch.
- cpu_ack  out  1  wishbone ACK to fetch.
- l2_adr  out  12  refill line address.
- l2_stb  out  1  refill STB.
- l2_cyc  out  1  refill CYC.
- l2_we  out  1  tied 0.
- l2_sel  out  16  tied all ones.
- l2_dat_s  in  128  refill data.
- l2_ack  in  1  refill ACK.
- inv  in  1  invalidate all lines.
- hit_count  out  CNT_W  hit counter.
- miss_count  out  CNT_W  miss counter.

Behaviour:
- Storage:
  - valid[SETS] flops, tag[SETS] x TAG, data[SETS] x 128.
  - index = cpu_adr[IDX-1:0]; tag field = cpu_adr[11:IDX].
- Reset (async, rst=1):
  - state=IDLE, all valid bits=0, hit_count=0, miss_count=0.
  - l2_stb=0, l2_cyc=0, l2_adr=0, cpu_ack=0.
  - Tag and data arrays are not reset.
- hit = state==IDLE & cpu_stb & cpu_cyc & !cpu_we & valid[index] & tag[index]==tag field.
- cpu_ack = hit, combinational and in the same cycle as the request.
  - cpu_dat_s = data[index], valid while cpu_ack=1; don't-care otherwise.
- States:
  - IDLE:
    - Request with !cpu_we and no hit → latch cpu_adr into l2_adr, go to FILL, miss_count += 1.
    - Hit → stay in IDLE, hit_count += 1 on every ACK cycle, including repeated ACKs while the CPU stalls on the same address.
  - FILL:
    - l2_stb = l2_cyc = 1, l2_adr held constant.
    - On l2_ack: write data[idx(l2_adr)] = l2_dat_s, write tag, set valid (unless cleared per the inv rule), drop STB/CYC in the next cycle, go to IDLE.
    - No cpu_ack while in FILL.
- Latency:
  - Hit: 0 cycles (combinational ACK).
  - Miss with a zero-wait L2: miss seen in cycle 0, l2_stb high in cycle 1 with l2_ack in cycle 1, back in IDLE in cycle 2, cpu_ack in cycle 2.
  - General case: cpu_ack 1 cycle after l2_ack.
- cpu_adr changing during FILL: the fill completes to the latched address, then IDLE re-evaluates the new address. This may cause back-to-back misses; this is correct and each one is counted.
- inv:
  - Clears all valid bits in the cycle it is sampled.
  - inv in IDLE while a hit is present: the ACK in that same cycle still completes.
  - inv during FILL, or coincident with l2_ack: the fill writes data and tag but leaves valid=0.
- Counters wrap modulo 2^CNT_W. There is no saturation.
- cpu_we=1 requests: never ACKed, never counted, state unchanged.
- Reset during FILL: l2_stb/l2_cyc deassert immediately (async). A late l2_ack after reset is ignored.
- l2_ack is ignored outside FILL.

Optional Feature:
- Macro: ICACHE_NEXT_LINE_PREFETCH_EN.
- Defined:
  - Adds state PREFETCH.
  - After every demand FILL completes, if line l2_adr+1 (mod 4096) is not present, the FSM spends one IDLE cycle (demand hits are served in it) and then issues the prefetch for l2_adr+1.
  - Prefetch fills do not increment miss_count.
  - A demand miss during PREFETCH waits for the prefetch to complete.
  - Adds output pf_count [CNT_W], incremented per issued prefetch, reset to 0.
- Undefined: no PREFETCH state, no pf_count port; behaviour exactly as above.

Test Plan:
- Cold miss: reset, cpu_adr=0x010, L2 acks 2 cycles after STB with data 128'hA5.. → l2_adr=0x010, cpu_ack 1 cycle after l2_ack, cpu_dat_s=128'hA5.., miss_count=1, hit_count=0.
- Hit then stall: after the cold miss, hold cpu_adr=0x010 for 4 cycles → cpu_ack=1 in every cycle, hit_count=4, l2_stb stays 0.
- Conflict (SETS=16): fill 0x010, then request 0x020 (same index 0) → miss, refill; re-request 0x010 → miss again; miss_count=3.
- inv during FILL: miss on 0x005, assert inv coincident with l2_ack → next cycle 0x005 misses again, second l2 request seen.
- Async reset mid-FILL: assert rst while l2_stb=1 → l2_stb/l2_cyc=0 immediately, counters=0; a later l2_ack pulse causes no state change; the previously valid line now misses.
- Counter wrap: with CNT_W=4, perform 17 hits → hit_count=1.
